nx1_zmemarb: RTL and testbench
==============================

Name: nx1_zmemarb

Overview:
- Parametrised N-channel byte-access arbiter onto the MCB-style memory FIFO port (cmd/wr/rd FIFOs).
- Successor to the single-CPU Z80 memory bridge: serves NCH byte requesters (CPU, DMA, loader, ...) with round-robin arbitration.
- Adds configurable data width, read timeout with error reporting, and draining of stray read data.
- Sits between the CPU/peripheral address decode and the memory controller.

Parameters:
- NCH, 2, number of requester channels (1..8)
- DW, 32, memory data width; 32 or 64; byte lanes BL=DW/8, LSB=log2(BL)
- AW, 30, byte address width
- TOUT, 255, read timeout in mem_clk cycles (8-bit counter)

Ports:
- mem_clk  in  1  clock
- mem_rst  in  1  reset, asynchronous, active-high
- mem_init_done  in  1  controller ready
- ch_req  in  NCH  level request per channel, held until ch_ack
- ch_wr  in  NCH  1=write, 0=read
- ch_addr  in  NCH*AW  byte address; channel i at [i*AW +: AW]
- ch_wdata  in  NCH*8  write byte; channel i at [i*8 +: 8]
- ch_ack  out  NCH  one-cycle completion pulse
- ch_err  out  NCH  timeout flag, valid with ch_ack
- ch_rdata  out  8  read byte; valid with ch_ack, held until next read completion
- busy  out  1  state != IDLE
- mem_cmd_en  out  1  command push
- mem_cmd_instr  out  3  3'b000 write, 3'b001 read
- mem_cmd_bl  out  6  constant 0 (single word)
- mem_cmd_byte_addr  out  AW  word-aligned address
- mem_cmd_full  in  1  cmd FIFO full
- mem_cmd_empty  in  1  cmd FIFO empty
- mem_wr_en  out  1  write-data push
- mem_wr_mask  out  BL  1=lane masked
- mem_wr_data  out  DW  write data
- mem_wr_full  in  1  wr FIFO full
- mem_rd_en  out  1  read-data pop
- mem_rd_data  in  DW  read data
- mem_rd_empty  in  1  rd FIFO empty

Behaviour:
- Reset: all outputs 0, except mem_wr_mask all-ones; state IDLE; last-grant pointer = NCH-1, so channel 0 wins first; timeout counter 0.
- States: IDLE, WDAT, CMD, WWAIT, RWAIT, DONE.
- IDLE:
  - If mem_rd_empty=0, pulse mem_rd_en to discard the stray word; no grant that cycle.
  - Else if mem_init_done=1 and any ch_req: grant the first requesting channel after the last-grant pointer (round-robin).
  - On grant, latch wr, addr, wdata and channel index.
  - Write -> WDAT; read -> CMD.
- WDAT: when mem_wr_full=0, pulse mem_wr_en for one cycle, then -> CMD.
  - mem_wr_data = wdata replicated BL times.
  - mem_wr_mask: only lane addr[LSB-1:0] = 0, all other lanes = 1.
- CMD: when mem_cmd_full=0, pulse mem_cmd_en for one cycle, then -> WWAIT (write) or RWAIT (read).
  - mem_cmd_byte_addr = addr with bits [LSB-1:0] zeroed.
- WWAIT: when mem_cmd_empty=1, pulse ch_ack[g] -> DONE.
- RWAIT: counter increments each cycle.
  - If mem_rd_empty=0: pulse mem_rd_en, set ch_rdata = lane addr[LSB-1:0] of mem_rd_data, pulse ch_ack[g] -> DONE.
  - Else if counter == TOUT: pulse ch_ack[g] and ch_err[g], set ch_rdata = 8'hFF -> DONE. The late word is later drained in IDLE.
  - Data arriving in the same cycle as the timeout takes priority, so no error is raised.
- DONE: one cycle; grant pointer updated to g; ch_req[g] is ignored this cycle so a requester dropping req one cycle late is not double-served; -> IDLE.
- Minimum latency from req to ack, with all FIFOs ready: read 4 cycles (ack with data present in the cycle after cmd_en); write 4 cycles.
- mem_init_done falling in any non-IDLE state: abort to IDLE with no ack and counter cleared. The requester keeps req high and is re-served once init_done returns.
- mem_rst asserted mid-operation: immediate return to reset values; the in-flight request is lost and no ack is issued.
- NCH=1: the arbiter degenerates to a fixed grant.

Test Plan:
- DW=32, ch0 write 8'hA5 to 30'h0000_1236 -> mem_wr_data=32'hA5A5A5A5, mask=4'b1011, cmd addr 30'h0000_1234, instr 000, one ch_ack[0] after cmd_empty.
- DW=64, ch1 read 30'h0000_0105, rd_data=64'h8877665544332211 returned 2 cycles after cmd_en -> ch_rdata=8'h66, ch_ack[1] one cycle, ch_err=0.
- ch0 and ch1 requesting continuously, 6 transactions -> grants alternate 0,1,0,1,0,1, starting with ch0 after reset.
- Read with rd_empty held 1 for TOUT=255 cycles -> ack with ch_err=1, rdata=8'hFF; stray word arriving afterwards -> drained in IDLE, no ack.
- mem_wr_full=1 for 10 cycles, then mem_cmd_full=1 for 5 cycles -> wr_en and cmd_en each pulse once only after release; single ack.
- mem_init_done dropped in RWAIT -> no ack, busy=0; restored with req still high -> request re-issued and acked. mem_rst mid-WDAT -> all outputs return to reset values.

Source files
------------

// File: rtl/nx1_zmemarb.sv
// nx1_zmemarb: round-robin arbiter that lets NCH byte-wide requesters share
// one MCB-style memory port (command, write-data and read-data FIFOs).
// Each byte access becomes a single-word command with a lane mask on writes
// and a lane select on reads. Reads time out after TOUT cycles, and any read
// word that arrives late is drained while idle.
//
// Handshake: a requester raises ch_req[i] with its address, direction and
// data, and holds all of them steady until it sees the one-cycle ch_ack[i].
// ch_err[i] and ch_rdata are valid in the ack cycle. Toward memory,
// mem_cmd_en and mem_wr_en are one-cycle pushes, issued only while the
// matching *_full input is low. mem_rd_en is a one-cycle pop, issued only
// while mem_rd_empty is low; mem_rd_data is first-word-fall-through.
module nx1_zmemarb #(
  parameter int NCH  = 2,
  parameter int DW   = 32,
  parameter int AW   = 30,
  parameter int TOUT = 255
) (
  input  logic                mem_clk,
  input  logic                mem_rst,
  input  logic                mem_init_done,
  input  logic [NCH-1:0]      ch_req,
  input  logic [NCH-1:0]      ch_wr,
  input  logic [NCH*AW-1:0]   ch_addr,
  input  logic [NCH*8-1:0]    ch_wdata,
  output logic [NCH-1:0]      ch_ack,
  output logic [NCH-1:0]      ch_err,
  output logic [7:0]          ch_rdata,
  output logic                busy,
  output logic                mem_cmd_en,
  output logic [2:0]          mem_cmd_instr,
  output logic [5:0]          mem_cmd_bl,
  output logic [AW-1:0]       mem_cmd_byte_addr,
  input  logic                mem_cmd_full,
  input  logic                mem_cmd_empty,
  output logic                mem_wr_en,
  output logic [DW/8-1:0]     mem_wr_mask,
  output logic [DW-1:0]       mem_wr_data,
  input  logic                mem_wr_full,
  output logic                mem_rd_en,
  input  logic [DW-1:0]       mem_rd_data,
  input  logic                mem_rd_empty,
  output logic [2:0]          dbg_state
);

  localparam int BL  = DW / 8;
  localparam int LSB = $clog2(BL);
  localparam int GW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [NCH-1:0] ONE    = 1;
  localparam logic [7:0]     TOUT_C = 8'(TOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WDAT  = 3'd1,
    CMD   = 3'd2,
    WWAIT = 3'd3,
    RWAIT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   ptr_q;
  logic [GW-1:0]   g_q;
  logic            wr_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      wdata_q;
  logic [7:0]      cnt_q;
  logic [NCH-1:0]  ch_ack_q;
  logic [NCH-1:0]  ch_err_q;
  logic [7:0]      ch_rdata_q;
  logic            mem_cmd_en_q;
  logic [2:0]      mem_cmd_instr_q;
  logic [AW-1:0]   mem_cmd_addr_q;
  logic            mem_wr_en_q;
  logic [BL-1:0]   mem_wr_mask_q;
  logic [DW-1:0]   mem_wr_data_q;
  logic            mem_rd_en_q;

  logic            arb_hit;
  logic [GW-1:0]   arb_idx;
  logic [LSB-1:0]  lane;

  assign lane = addr_q[LSB-1:0];

  // Round-robin pick: the first requesting channel after the last grant.
  always_comb begin
    int c;
    c       = 0;
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int k = 1; k <= NCH; k++) begin
      c = (int'(ptr_q) + k) % NCH;
      if (!arb_hit && ch_req[c]) begin
        arb_hit = 1'b1;
        arb_idx = GW'(c);
      end
    end
  end

  // Main sequencer: grant, push write data, push command, wait, acknowledge.
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      state_q         <= IDLE;
      ptr_q           <= GW'(NCH - 1);
      g_q             <= '0;
      wr_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      cnt_q           <= '0;
      ch_ack_q        <= '0;
      ch_err_q        <= '0;
      ch_rdata_q      <= '0;
      mem_cmd_en_q    <= 1'b0;
      mem_cmd_instr_q <= '0;
      mem_cmd_addr_q  <= '0;
      mem_wr_en_q     <= 1'b0;
      mem_wr_mask_q   <= '1;
      mem_wr_data_q   <= '0;
      mem_rd_en_q     <= 1'b0;
    end else begin
      mem_cmd_en_q <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      ch_ack_q     <= '0;
      ch_err_q     <= '0;
      if (state_q != IDLE && !mem_init_done) begin
        // Controller lost calibration: abandon the access silently.
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (mem_rd_en_q) begin
              // A pop is in flight; rd_empty does not reflect it yet.
            end else if (!mem_rd_empty) begin
              mem_rd_en_q <= 1'b1;
            end else if (mem_init_done && arb_hit) begin
              g_q     <= arb_idx;
              wr_q    <= ch_wr[arb_idx];
              addr_q  <= ch_addr[arb_idx*AW +: AW];
              wdata_q <= ch_wdata[arb_idx*8 +: 8];
              state_q <= ch_wr[arb_idx] ? WDAT : CMD;
            end
          end
          WDAT: begin
            if (!mem_wr_full) begin
              mem_wr_en_q   <= 1'b1;
              mem_wr_data_q <= {BL{wdata_q}};
              mem_wr_mask_q <= ~(BL'(1) << lane);
              state_q       <= CMD;
            end
          end
          CMD: begin
            if (!mem_cmd_full) begin
              mem_cmd_en_q    <= 1'b1;
              mem_cmd_instr_q <= wr_q ? 3'b000 : 3'b001;
              mem_cmd_addr_q  <= {addr_q[AW-1:LSB], {LSB{1'b0}}};
              cnt_q           <= '0;
              state_q         <= wr_q ? WWAIT : RWAIT;
            end
          end
          WWAIT: begin
            if (mem_cmd_empty) begin
              ch_ack_q <= ONE << g_q;
              state_q  <= DONE;
            end
          end
          RWAIT: begin
            if (!mem_rd_empty) begin
              mem_rd_en_q <= 1'b1;
              ch_rdata_q  <= mem_rd_data[lane*8 +: 8];
              ch_ack_q    <= ONE << g_q;
              cnt_q       <= '0;
              state_q     <= DONE;
            end else if (cnt_q == TOUT_C) begin
              ch_ack_q   <= ONE << g_q;
              ch_err_q   <= ONE << g_q;
              ch_rdata_q <= 8'hFF;
              cnt_q      <= '0;
              state_q    <= DONE;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          DONE: begin
            // The just-served channel may still hold req this cycle; no
            // grant happens here, and the pointer moves past it.
            ptr_q   <= g_q;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ch_ack            = ch_ack_q;
  assign ch_err            = ch_err_q;
  assign ch_rdata          = ch_rdata_q;
  assign busy              = (state_q != IDLE);
  assign mem_cmd_en        = mem_cmd_en_q;
  assign mem_cmd_instr     = mem_cmd_instr_q;
  assign mem_cmd_bl        = 6'd0;
  assign mem_cmd_byte_addr = mem_cmd_addr_q;
  assign mem_wr_en         = mem_wr_en_q;
  assign mem_wr_mask       = mem_wr_mask_q;
  assign mem_wr_data       = mem_wr_data_q;
  assign mem_rd_en         = mem_rd_en_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_nx1_zmemarb.sv
// Directed bench for nx1_zmemarb. Two instances (DW=32 and DW=64) share all
// inputs and run in lockstep, so lane handling is checked for both widths.
module tb_nx1_zmemarb;

  logic        mem_clk = 1'b0;
  logic        mem_rst;
  logic        mem_init_done;
  logic [1:0]  ch_req, ch_wr;
  logic [59:0] ch_addr;
  logic [15:0] ch_wdata;
  logic        mem_cmd_full, mem_cmd_empty, mem_wr_full, mem_rd_empty;
  logic [63:0] mem_rd_data;

  logic [1:0]  ch_ack, ch_err;
  logic [7:0]  ch_rdata;
  logic        busy, mem_cmd_en, mem_wr_en, mem_rd_en;
  logic [2:0]  mem_cmd_instr, dbg_state;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic [3:0]  mem_wr_mask;
  logic [31:0] mem_wr_data;

  logic [1:0]  d64_ack, d64_err;
  logic [7:0]  d64_rdata;
  logic        d64_busy, d64_cmd_en, d64_wr_en, d64_rd_en;
  logic [2:0]  d64_instr, d64_state;
  logic [5:0]  d64_bl;
  logic [29:0] d64_addr;
  logic [7:0]  d64_mask;
  logic [63:0] d64_wdata;

  // clock / reset
  always #5 mem_clk = ~mem_clk;

  nx1_zmemarb #(.NCH(2), .DW(32), .AW(30), .TOUT(255)) u_dut32 (
    .mem_clk(mem_clk), .mem_rst(mem_rst), .mem_init_done(mem_init_done),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_ack(ch_ack), .ch_err(ch_err), .ch_rdata(ch_rdata), .busy(busy),
    .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
    .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_cmd_full(mem_cmd_full),
    .mem_cmd_empty(mem_cmd_empty), .mem_wr_en(mem_wr_en), .mem_wr_mask(mem_wr_mask),
    .mem_wr_data(mem_wr_data), .mem_wr_full(mem_wr_full), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data[31:0]), .mem_rd_empty(mem_rd_empty), .dbg_state(dbg_state)
  );

  nx1_zmemarb #(.NCH(2), .DW(64), .AW(30), .TOUT(255)) u_dut64 (
    .mem_clk(mem_clk), .mem_rst(mem_rst), .mem_init_done(mem_init_done),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_ack(d64_ack), .ch_err(d64_err), .ch_rdata(d64_rdata), .busy(d64_busy),
    .mem_cmd_en(d64_cmd_en), .mem_cmd_instr(d64_instr), .mem_cmd_bl(d64_bl),
    .mem_cmd_byte_addr(d64_addr), .mem_cmd_full(mem_cmd_full),
    .mem_cmd_empty(mem_cmd_empty), .mem_wr_en(d64_wr_en), .mem_wr_mask(d64_mask),
    .mem_wr_data(d64_wdata), .mem_wr_full(mem_wr_full), .mem_rd_en(d64_rd_en),
    .mem_rd_data(mem_rd_data), .mem_rd_empty(mem_rd_empty), .dbg_state(d64_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // monitor state
  int          tick_n = 0;
  int          n_wr = 0, n_cmd = 0, n_rd = 0, n_ack = 0;
  int          ack_tick = 0, cmd_tick = 0;
  logic [31:0] last_wd;   logic [3:0] last_mask; logic [29:0] last_addr; logic [2:0] last_instr;
  logic [63:0] last_wd64; logic [7:0] last_mask64; logic [29:0] last_addr64;
  logic [1:0]  last_ack, last_err;
  logic [7:0]  last_rdata, last_rdata64;
  logic [1:0]  grant_q[$];
  logic [1:0]  exp_q[$];
  bit          auto_drop = 1'b1;
  int          rsp_delay_cfg = -1, rsp_cnt = 0;
  logic [63:0] rsp_data = '0;
  int          cmd_hold_cfg = 0, cmd_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample after the edge, then act as requesters and FIFOs.
  task automatic tick();
    @(posedge mem_clk); #1;
    tick_n++;
    if (mem_wr_en)  begin n_wr++; last_wd = mem_wr_data; last_mask = mem_wr_mask; end
    if (d64_wr_en)  begin last_wd64 = d64_wdata; last_mask64 = d64_mask; end
    if (d64_cmd_en) last_addr64 = d64_addr;
    if (d64_ack != 2'b00) last_rdata64 = d64_rdata;
    if (ch_ack != 2'b00) begin
      n_ack++; ack_tick = tick_n; last_ack = ch_ack; last_err = ch_err; last_rdata = ch_rdata;
      grant_q.push_back(ch_ack[1] ? 2'd1 : 2'd0);
      if (auto_drop) ch_req = ch_req & ~ch_ack;
    end
    if (mem_rd_en) begin n_rd++; mem_rd_empty = 1'b1; end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin mem_rd_empty = 1'b0; mem_rd_data = rsp_data; end
    end
    if (cmd_cnt > 0) begin
      cmd_cnt--;
      if (cmd_cnt == 0) mem_cmd_empty = 1'b1;
    end
    if (mem_cmd_en) begin
      n_cmd++; cmd_tick = tick_n; last_addr = mem_cmd_byte_addr; last_instr = mem_cmd_instr;
      if (mem_cmd_instr == 3'b001 && rsp_delay_cfg > 0) rsp_cnt = rsp_delay_cfg;
      if (cmd_hold_cfg > 0) begin mem_cmd_empty = 1'b0; cmd_cnt = cmd_hold_cfg; end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int target;
    int k;
    target = n_ack + 1;
    k = 0;
    while (n_ack < target && k < budget) begin tick(); k++; end
    chk(tag, n_ack, target);
  endtask

  task automatic req(input int ch, input bit wr, input logic [29:0] a, input logic [7:0] d);
    ch_wr[ch]          = wr;
    ch_addr[ch*30 +: 30] = a;
    ch_wdata[ch*8 +: 8]  = d;
    ch_req[ch]         = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  busy, 1'b0);
    chk({tag, "_ack"},   ch_ack, 2'b00);
    chk({tag, "_en"},    {mem_wr_en, mem_cmd_en, mem_rd_en}, 3'b000);
    chk({tag, "_mask"},  mem_wr_mask, 4'hF);
    chk({tag, "_mask64"}, d64_mask, 8'hFF);
    chk({tag, "_wdata"}, mem_wr_data, 32'h0);
    chk({tag, "_caddr"}, mem_cmd_byte_addr, 30'h0);
    chk({tag, "_state"}, dbg_state, 3'd0);
  endtask

  int t0, n0, a0, c0;

  initial begin
    mem_rst = 1'b1; mem_init_done = 1'b1;
    ch_req = '0; ch_wr = '0; ch_addr = '0; ch_wdata = '0;
    mem_cmd_full = 1'b0; mem_cmd_empty = 1'b1; mem_wr_full = 1'b0;
    mem_rd_empty = 1'b1; mem_rd_data = '0;
    ticks(3);
    chk_reset_outputs("reset");
    chk("reset_bl", mem_cmd_bl, 6'd0);
    mem_rst = 1'b0;
    ticks(2);

    // ch0 write A5 to 0x1236, cmd FIFO holds the command for 3 cycles
    cmd_hold_cfg = 3;
    req(0, 1'b1, 30'h0000_1236, 8'hA5);
    t0 = tick_n;
    wait_ack("w_ack", 20);
    chk("w_lat", ack_tick - t0, 7);
    chk("w_data", last_wd, 32'hA5A5_A5A5);
    chk("w_mask", last_mask, 4'b1011);
    chk("w_addr", last_addr, 30'h0000_1234);
    chk("w_instr", last_instr, 3'b000);
    chk("w_data64", last_wd64, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("w_mask64", last_mask64, 8'hBF);
    chk("w_addr64", last_addr64, 30'h0000_1230);
    chk("w_ackv", last_ack, 2'b01);
    cmd_hold_cfg = 0;
    ticks(3);
    chk("w_counts", {8'(n_wr), 8'(n_cmd), 8'(n_ack)}, {8'd1, 8'd1, 8'd1});

    // ch1 read 0x105, data returned 2 cycles after cmd_en
    rsp_delay_cfg = 2; rsp_data = 64'h8877_6655_4433_2211;
    req(1, 1'b0, 30'h0000_0105, 8'h00);
    t0 = tick_n;
    wait_ack("r_ack", 20);
    chk("r_lat", ack_tick - t0, 5);
    chk("r_ackv", last_ack, 2'b10);
    chk("r_err", last_err, 2'b00);
    chk("r_rdata32", last_rdata, 8'h22);
    chk("r_rdata64", last_rdata64, 8'h66);
    chk("r_instr", last_instr, 3'b001);
    chk("r_addr", last_addr, 30'h0000_0104);
    chk("r_addr64", last_addr64, 30'h0000_0100);
    ticks(3);
    chk("r_drained", mem_rd_empty, 1'b1);
    rsp_delay_cfg = -1;

    // both channels requesting continuously: writes alternate 0,1,...
    grant_q.delete();
    auto_drop = 1'b0;
    req(0, 1'b1, 30'h10, 8'h11);
    req(1, 1'b1, 30'h20, 8'h22);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(2'(i % 2));
      wait_ack("rr_ack", 20);
    end
    ch_req = '0;
    auto_drop = 1'b1;
    ticks(3);
    chk("rr_count", grant_q.size(), 6);
    while (exp_q.size() > 0 && grant_q.size() > 0)
      chk("rr_grant", grant_q.pop_front(), exp_q.pop_front());

    // read timeout, then the late word is drained without an ack
    req(0, 1'b0, 30'h0000_0042, 8'h00);
    wait_ack("to_ack", 300);
    chk("to_lat", ack_tick - cmd_tick, 256);
    chk("to_err", last_err, 2'b01);
    chk("to_rdata", last_rdata, 8'hFF);
    ticks(3);
    n0 = n_rd; a0 = n_ack;
    mem_rd_data = 64'hDEAD_BEEF_DEAD_BEEF; mem_rd_empty = 1'b0;
    ticks(5);
    chk("drain_rd", n_rd - n0, 1);
    chk("drain_noack", n_ack - a0, 0);
    chk("drain_busy", busy, 1'b0);

    // write-data then command FIFO back-pressure
    n0 = n_wr; c0 = n_cmd; a0 = n_ack;
    mem_wr_full = 1'b1; mem_cmd_full = 1'b1;
    req(1, 1'b1, 30'h0000_0301, 8'h3C);
    ticks(10);
    chk("bp_wr_held", n_wr - n0, 0);
    mem_wr_full = 1'b0;
    ticks(5);
    chk("bp_wr_once", n_wr - n0, 1);
    chk("bp_cmd_held", n_cmd - c0, 0);
    mem_cmd_full = 1'b0;
    wait_ack("bp_ack", 20);
    ticks(3);
    chk("bp_counts", {8'(n_wr - n0), 8'(n_cmd - c0), 8'(n_ack - a0)}, {8'd1, 8'd1, 8'd1});
    chk("bp_mask", last_mask, 4'b1101);

    // init_done drop in RWAIT aborts; restore re-serves the held request
    c0 = n_cmd; a0 = n_ack;
    req(0, 1'b0, 30'h0000_0003, 8'h00);
    ticks(4);
    chk("init_rwait", dbg_state, 3'd4);
    mem_init_done = 1'b0;
    tick();
    chk("init_busy", busy, 1'b0);
    ticks(3);
    chk("init_idle", busy, 1'b0);
    chk("init_noack", n_ack - a0, 0);
    rsp_delay_cfg = 1; rsp_data = 64'hF0E0_D0C0_B0A0_9080;
    mem_init_done = 1'b1;
    t0 = tick_n;
    wait_ack("init_ack", 20);
    chk("init_lat", ack_tick - t0, 4);
    chk("init_rdata", last_rdata, 8'hB0);
    chk("init_err", last_err, 2'b00);
    chk("init_cmds", n_cmd - c0, 2);
    rsp_delay_cfg = -1;
    ticks(3);

    // reset in the middle of WDAT
    mem_wr_full = 1'b1;
    req(1, 1'b1, 30'h0000_0777, 8'h5A);
    ticks(2);
    chk("rst_wdat", dbg_state, 3'd1);
    mem_rst = 1'b1; #1;
    chk_reset_outputs("rst_mid");
    ch_req = '0; mem_wr_full = 1'b0;
    ticks(2);
    mem_rst = 1'b0;
    ticks(2);

    // after reset channel 0 wins first, minimum write latency
    a0 = n_ack;
    req(0, 1'b1, 30'h0000_0008, 8'h77);
    req(1, 1'b1, 30'h0000_0009, 8'h88);
    t0 = tick_n;
    wait_ack("post_ack", 20);
    chk("post_ch0", last_ack, 2'b01);
    chk("post_lat", ack_tick - t0, 4);
    wait_ack("post_ack2", 20);
    chk("post_ch1", last_ack, 2'b10);
    ticks(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=%0d", tick_n, 0);
    $fatal(1, "timeout");
  end

endmodule
